// File: rtl/pc_gen_if.sv
// Fetch-stage PC interface: redirect/stall controls in, fetch address and status out.
interface pc_gen_if #(parameter int ADDR_W = 32);
  logic              stall;
  logic              branch_flag;
  logic [ADDR_W-1:0] branch_target;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              ce;
  logic [ADDR_W-1:0] pc;
  logic              pend_valid;
  logic              misalign;

  modport master (
    output stall, branch_flag, branch_target, flush, flush_pc,
    input  ce, pc, pend_valid, misalign
  );

  modport slave (
    input  stall, branch_flag, branch_target, flush, flush_pc,
    output ce, pc, pend_valid, misalign
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: registered pc/ce, redirects take effect one edge later.
// A branch seen under stall is buffered and applied on stall release; flush overrides all.
module pc_gen #(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              INC        = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);

  logic [ADDR_W-1:0] pend_tgt;
  logic              apply;
  logic [ADDR_W-1:0] tgt;

  always_comb begin
    apply = 1'b0;
    tgt   = bus.flush_pc;
    if (bus.flush) begin
      apply = 1'b1;
      tgt   = bus.flush_pc;
    end else if (bus.stall) begin
      apply = 1'b0;
    end else if (bus.branch_flag) begin
      apply = 1'b1;
      tgt   = bus.branch_target;
    end else if (bus.pend_valid) begin
      apply = 1'b1;
      tgt   = pend_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ce         <= 1'b0;
      bus.pc         <= RESET_VEC;
      bus.pend_valid <= 1'b0;
      bus.misalign   <= 1'b0;
      pend_tgt       <= '0;
    end else if (!bus.ce) begin
      bus.ce       <= 1'b1;
      bus.misalign <= 1'b0;
    end else begin
      bus.misalign <= 1'b0;
      if (apply) begin
        // Low bits are checked only at the point of use; pend_tgt keeps the raw value.
        bus.pc         <= tgt & ~LOW_MASK;
        bus.misalign   <= |(tgt & LOW_MASK);
        bus.pend_valid <= 1'b0;
      end else if (bus.stall) begin
        if (bus.branch_flag) begin
          pend_tgt       <= bus.branch_target;
          bus.pend_valid <= 1'b1;
        end
      end else begin
        bus.pc <= bus.pc + ADDR_W'(INC);
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed table-driven bench for pc_gen with hand-computed expectations.
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_gen_if #(.ADDR_W(32)) bus ();

  pc_gen #(
    .ADDR_W(32), .RESET_VEC(32'h0000_0000), .INC(4), .ALIGN_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bf;
    logic [31:0] bt;
    logic        flush;
    logic [31:0] fpc;
    logic        e_ce;
    logic [31:0] e_pc;
    logic        e_pv;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic f, input logic [31:0] fp,
                     input logic ece, input logic [31:0] epc, input logic epv, input logic emis);
    vec_t v;
    v.rst = r; v.stall = s; v.bf = b; v.bt = t; v.flush = f; v.fpc = fp;
    v.e_ce = ece; v.e_pc = epc; v.e_pv = epv; v.e_mis = emis;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic f, input logic [31:0] fp);
    rst = r; bus.stall = s; bus.branch_flag = b; bus.branch_target = t;
    bus.flush = f; bus.flush_pc = fp;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int idx, input logic ece, input logic [31:0] epc,
                            input logic epv, input logic emis);
    chk("ce", idx, {31'b0, bus.ce}, {31'b0, ece});
    chk("pc", idx, bus.pc, epc);
    chk("pend_valid", idx, {31'b0, bus.pend_valid}, {31'b0, epv});
    chk("misalign", idx, {31'b0, bus.misalign}, {31'b0, emis});
  endtask

  initial begin
    bus.stall = 0; bus.branch_flag = 0; bus.branch_target = '0;
    bus.flush = 0; bus.flush_pc = '0;

    //   rst s  b  target        f  flush_pc      ce pc            pv mis
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 0);
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h8,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'hC,        0, 0);
    add(0, 0, 1, 32'h100,       0, 32'h0,        1, 32'h100,      0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h100,      0, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h100,      0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h104,      0, 0);
    add(0, 0, 1, 32'h200,       0, 32'h0,        1, 32'h200,      0, 0);
    add(0, 1, 1, 32'h400,       0, 32'h0,        1, 32'h200,      1, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h200,      1, 0);
    add(0, 1, 0, 32'h0,         0, 32'h0,        1, 32'h200,      1, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h400,      0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h404,      0, 0);
    add(0, 1, 1, 32'h400,       0, 32'h0,        1, 32'h404,      1, 0);
    add(0, 0, 1, 32'h800,       0, 32'h0,        1, 32'h800,      0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h804,      0, 0);
    add(0, 1, 1, 32'h400,       1, 32'h180,      1, 32'h180,      0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h184,      0, 0);
    add(0, 0, 1, 32'h306,       0, 32'h0,        1, 32'h304,      0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h308,      0, 0);
    add(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h0,        0, 0);
    add(0, 1, 1, 32'h10,        0, 32'h0,        1, 32'h0,        1, 0);
    add(1, 0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        0, 0);
    add(0, 1, 1, 32'h44,        1, 32'h700,      1, 32'h0,        0, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h4,        0, 0);
    add(0, 0, 0, 32'h0,         1, 32'h181,      1, 32'h180,      0, 1);
    add(0, 1, 1, 32'h503,       0, 32'h0,        1, 32'h180,      1, 0);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h500,      0, 1);
    add(0, 0, 0, 32'h0,         0, 32'h0,        1, 32'h504,      0, 0);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].bf, vecs[i].bt, vecs[i].flush, vecs[i].fpc);
      expect_out(i, vecs[i].e_ce, vecs[i].e_pc, vecs[i].e_pv, vecs[i].e_mis);
    end

    // Flush under stall drops a pending branch; release then increments from flush_pc.
    drive(0, 1, 1, 32'h900, 0, 32'h0); expect_out(100, 1, 32'h504, 1, 0);
    drive(0, 1, 0, 32'h0,   1, 32'h600); expect_out(101, 1, 32'h600, 0, 0);
    drive(0, 0, 0, 32'h0,   0, 32'h0); expect_out(102, 1, 32'h604, 0, 0);

    // Back-to-back stalled branches: the newest target wins on release.
    drive(0, 1, 1, 32'hA00, 0, 32'h0); expect_out(103, 1, 32'h604, 1, 0);
    drive(0, 1, 1, 32'hB02, 0, 32'h0); expect_out(104, 1, 32'h604, 1, 0);
    drive(0, 0, 0, 32'h0,   0, 32'h0); expect_out(105, 1, 32'hB00, 0, 1);
    drive(0, 0, 0, 32'h0,   0, 32'h0); expect_out(106, 1, 32'hB04, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage.
- Produces the instruction-memory address and chip-enable.
- Supports pipeline stall, branch/jump redirect with a pending-redirect buffer while stalled, and exception/flush redirect.
- Sits between the control/ID stages, which supply stall, branch and flush, and the external instruction memory, which consumes pc and ce.

Parameters:
ADDR_W, 32, width of pc and all target addresses
RESET_VEC, 32'h0000_0000, first fetch address after reset
INC, 4, byte increment per sequential fetch
ALIGN_BITS, 2, number of low address bits that must be zero; 0 disables alignment handling

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
stall  input  1  hold pc; from pipeline control
branch_flag  input  1  redirect request from ID stage
branch_target  input  ADDR_W  redirect address, valid with branch_flag
flush  input  1  exception/flush redirect, highest priority
flush_pc  input  ADDR_W  exception/flush target, valid with flush
ce  output  1  instruction-memory enable
pc  output  ADDR_W  fetch address, registered
pend_valid  output  1  a redirect is buffered awaiting stall release
misalign  output  1  one-cycle pulse: the last applied target had nonzero low ALIGN_BITS

Behaviour:
Reset and enable:
- While rst=1 at the edge: ce<=0, pc<=RESET_VEC, pend_valid<=0, pending target<=0, misalign<=0.
- ce<=1 on the first edge with rst=0, and stays 1 until the next reset.
- While ce=0, pc holds RESET_VEC. All of stall, branch_flag and flush are ignored. Consequently the first enabled fetch address is RESET_VEC.
- rst mid-operation: abandons any pending redirect. The sequence restarts exactly as from power-up.

Update rules when ce=1, evaluated in this priority order each edge:
1. flush=1: pc<=flush_pc; pend_valid<=0. Applies regardless of stall or branch_flag.
2. stall=1 and branch_flag=1: pc holds; pending<=branch_target; pend_valid<=1. A newer branch overwrites an older pending target.
3. stall=1, branch_flag=0: pc and pending hold.
4. stall=0, branch_flag=1: pc<=branch_target; pend_valid<=0. The current branch beats a pending one.
5. stall=0, pend_valid=1: pc<=pending; pend_valid<=0.
6. Otherwise: pc<=pc+INC, truncated to ADDR_W bits; wraps from 2^ADDR_W-INC to 0 silently.

Alignment (ALIGN_BITS>0):
- Any target written into pc (flush_pc, branch_target, pending) has its low ALIGN_BITS forced to 0.
- misalign<=1 for exactly the cycle after such a write when the original low bits were nonzero; otherwise misalign<=0.
- The pending register stores the raw target. The check is made when the target is applied.
- RESET_VEC and increment results are not checked.

Timing:
- Latency from a redirect input to the pc change is one edge.
- pc and ce are pure registers; no combinational path from inputs to outputs.

Test Plan:
1. rst high 3 cycles then low, no other inputs -> ce=0 and pc=0 during reset; the edge after release gives ce=1, pc=0; following edges give pc=4, 8, 12.
2. Free run from pc=0x100, stall high 2 cycles -> pc stays 0x100 for 2 cycles, then 0x104.
3. pc=0x200, stall=1 with branch_flag=1 and target 0x400, then stall held 2 more cycles with branch_flag=0 -> pc holds 0x200 and pend_valid=1 throughout; first edge with stall=0 gives pc=0x400, pend_valid=0, then pc=0x404.
4. Pending 0x400, then on stall release branch_flag=1 with target 0x800 in the same cycle -> pc=0x800; pending discarded.
5. stall=1, branch_flag=1 with target 0x400, and flush=1 with flush_pc 0x180 in the same cycle -> pc=0x180, pend_valid=0.
6. branch_target 0x0000_0306 -> pc=0x304, misalign pulses 1 for one cycle. Separately, pc=0xFFFF_FFFC free-running -> next pc=0x0000_0000. Separately, asserting rst with pend_valid=1 -> pend_valid=0, ce=0, pc=RESET_VEC.
